// File: rtl/prio_enc_stream_pkg.sv
// Shared types and helpers for the streaming priority encoder.
// Vectors up to MAX_W bits are supported by the popcount helper.
package enc_pkg;

  localparam int unsigned MAX_W = 256;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  // True when at most one bit is set: clearing the lowest set bit leaves zero.
  function automatic logic popcount_le1(input logic [MAX_W-1:0] vec);
    return (vec == '0) || ((vec & (vec - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/prio_enc_stream_if.sv
// Request/response bundle for prio_enc_stream: vector in, index beats out.
interface prio_enc_stream_if #(
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_none;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none
  );

endinterface

// File: rtl/prio_enc_stream_prio_enc.sv
// Combinational priority encoder: index of the lowest (or highest) set bit.
module prio_enc #(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // Later matches overwrite earlier ones, so scan direction sets priority.
    if (MSB_FIRST) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (vec_i[i]) idx_o = IDX_W'(i);
      end
    end else begin
      for (int unsigned i = WIDTH; i > 0; i--) begin
        if (vec_i[i-1]) idx_o = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/prio_enc_stream.sv
// Accepts a multi-hot request vector and streams out the index of every set
// bit, one per beat; all outputs decode from registered state only.
module prio_enc_stream
  import enc_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  prio_enc_stream_if.slave   bus
);

  if (WIDTH < 2 || WIDTH > int'(MAX_W)) begin : g_width_chk
    $error("prio_enc_stream: WIDTH out of supported range");
  end

  enc_state_t       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             none_q, none_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             last;

  prio_enc #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio_enc (
    .vec_i (pending_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign last = popcount_le1(MAX_W'(pending_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    none_d        = none_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    bus.out_none  = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          pending_d = bus.in_vec;
          none_d    = (bus.in_vec == '0);
          state_d   = EMIT;
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_idx   = enc_any ? enc_idx : '0;
        bus.out_last  = last;
        bus.out_none  = none_q;
        if (bus.out_ready) begin
          // An all-zero vector clears bit 0 of an empty map: a harmless no-op.
          pending_d = pending_q & ~(WIDTH'(1) << enc_idx);
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  a_idx_range: assert property (
    @(posedge clk) disable iff (!rst_n)
      bus.out_valid |-> (int'(bus.out_idx) < WIDTH)
  );

  a_stall_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
      (bus.out_valid && !bus.out_ready) |=>
        (bus.out_valid && $stable(bus.out_idx) && $stable(bus.out_last) &&
         $stable(bus.out_none))
  );

endmodule
